lc2k_fetch: RTL and testbench

- Fetch-side initiator for the LC-2K instruction memory: owns the PC, drives the word address into the combinational-read imem, and registers the returned instruction into a one-entry output buffer for decode.
- Uses a valid/ready handshake toward decode, accepts a redirect from execute for beq/jalr, detects halt, and flags out-of-range fetches.

---
 rtl/lc2k_fetch.sv | 134 +++++++++++++
 tb/tb_lc2k_fetch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lc2k_fetch.sv
// rtl/lc2k_fetch.sv - LC-2K fetch stage: PC owner, imem address driver, one-entry output buffer
//
// Fetches one word per cycle from a combinational-read imem into a one-entry
// buffer that is handed to decode with a valid/ready handshake.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   imem_pc         : word address to imem (full PC, imem truncates)
//   imem_instr      : instruction returned combinationally for imem_pc
//   out_valid/out_ready/out_instr/out_pc : buffered instruction toward decode
//   redirect_valid/redirect_pc           : single-cycle PC change from execute
//   halted          : halt instruction consumed by decode (sticky)
//   fault           : fetch attempted with PC >= IMEM_DEPTH (sticky)
module lc2k_fetch #(
    parameter int PC_WIDTH   = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int RESET_PC   = 0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_pc,
    input  logic [31:0]         imem_instr,
    output logic                out_valid,
    output logic [31:0]         out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    input  logic                out_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] DEPTH_PC = PC_WIDTH'(IMEM_DEPTH);
    localparam logic [2:0]          OP_HALT  = 3'b110;

    state_t              r_state,     w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc,        w_pc_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic [31:0]         r_out_instr, w_out_instr_nxt;
    logic [PC_WIDTH-1:0] r_out_pc,    w_out_pc_nxt;
    logic                r_halted,    w_halted_nxt;
    logic                r_fault,     w_fault_nxt;

    logic w_transfer;
    logic w_can_fetch;
    logic w_in_range;

    assign w_transfer  = r_out_valid && out_ready;
    // Buffer is free when empty or being drained this cycle; a redirect wins.
    assign w_can_fetch = (r_state == RUN) && (!r_out_valid || out_ready) && !redirect_valid;
    assign w_in_range  = r_pc < DEPTH_PC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pc        <= PC_WIDTH'(RESET_PC);
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_halted    <= w_halted_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_instr_nxt = r_out_instr;
        w_out_pc_nxt    = r_out_pc;
        w_halted_nxt    = r_halted;
        w_fault_nxt     = r_fault;

        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    // Flush even if decode is accepting: the buffered word is on the wrong path.
                    w_out_valid_nxt = 1'b0;
                    w_pc_nxt        = redirect_pc;
                end else if (w_can_fetch) begin
                    if (w_in_range) begin
                        w_out_instr_nxt = imem_instr;
                        w_out_pc_nxt    = r_pc;
                        w_out_valid_nxt = 1'b1;
                        w_pc_nxt        = r_pc + PC_WIDTH'(1);
                        if (imem_instr[24:22] == OP_HALT) begin
                            w_state_nxt = DRAIN;
                        end
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_fault_nxt     = 1'b1;
                        w_state_nxt     = FAULT;
                    end
                end
            end
            DRAIN: begin
                // The halt may be speculative behind a taken branch, so a redirect revives fetch.
                if (redirect_valid) begin
                    w_out_valid_nxt = 1'b0;
                    w_pc_nxt        = redirect_pc;
                    w_state_nxt     = RUN;
                end else if (w_transfer) begin
                    w_out_valid_nxt = 1'b0;
                    w_halted_nxt    = 1'b1;
                    w_state_nxt     = HALTED;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign imem_pc   = r_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign halted    = r_halted;
    assign fault     = r_fault;

endmodule

// File: tb/tb_lc2k_fetch.sv
// tb/tb_lc2k_fetch.sv - directed table-driven bench for lc2k_fetch
module tb_lc2k_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc[7:0]];

    lc2k_fetch #(.PC_WIDTH(32), .IMEM_DEPTH(256), .RESET_PC(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fault          (fault)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_halted;
        logic        e_fault;
        logic [31:0] e_imem_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_halted, input logic e_fault, input logic [31:0] e_imem_pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_halted = e_halted; v.e_fault = e_fault; v.e_imem_pc = e_imem_pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] W0 = 32'h000E0001;
    localparam logic [31:0] W1 = 32'h00130004;
    localparam logic [31:0] W2 = 32'h006F0005;
    localparam logic [31:0] W3 = 32'h01800000;

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3; mem[255] = W0;

        //  rst rdy rv rpc     valid pc   instr halted fault imem_pc
        // straight-line run to halt
        add(1, 1, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 1, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 1, 0, 0,        1, 1,   W1, 0, 0, 2);
        add(0, 1, 0, 0,        1, 2,   W2, 0, 0, 3);
        add(0, 1, 0, 0,        1, 3,   W3, 0, 0, 4);
        add(0, 1, 0, 0,        0, 3,   W3, 1, 0, 4);
        add(0, 1, 0, 0,        0, 3,   W3, 1, 0, 4);
        // stall for three cycles after first valid
        add(1, 1, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 0, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 0, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 0, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 0, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 1, 0, 0,        1, 1,   W1, 0, 0, 2);
        add(0, 1, 0, 0,        1, 2,   W2, 0, 0, 3);
        // redirect concurrent with transfer of pc 1
        add(1, 1, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 1, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 1, 0, 0,        1, 1,   W1, 0, 0, 2);
        add(0, 1, 1, 0,        0, 1,   W1, 0, 0, 0);
        add(0, 1, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 1, 1, 2,        0, 0,   W0, 0, 0, 2);
        add(0, 1, 0, 0,        1, 2,   W2, 0, 0, 3);
        // halt parked in buffer, then redirected away
        add(1, 0, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 0, 1, 3,        0, 0,   0,  0, 0, 3);
        add(0, 0, 0, 0,        1, 3,   W3, 0, 0, 4);
        add(0, 0, 0, 0,        1, 3,   W3, 0, 0, 4);
        add(0, 0, 1, 1,        0, 3,   W3, 0, 0, 1);
        add(0, 0, 0, 0,        1, 1,   W1, 0, 0, 2);
        // last in-range word, then out-of-range fault
        add(1, 1, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 1, 1, 255,      0, 0,   0,  0, 0, 255);
        add(0, 1, 0, 0,        1, 255, W0, 0, 0, 256);
        add(0, 1, 0, 0,        0, 255, W0, 0, 1, 256);
        add(0, 1, 1, 5,        0, 255, W0, 0, 1, 256);
        add(0, 1, 0, 0,        0, 255, W0, 0, 1, 256);
        // reset out of FAULT, run to HALTED, reset; then reset while stalled
        add(1, 1, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 1, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 1, 0, 0,        1, 1,   W1, 0, 0, 2);
        add(0, 1, 0, 0,        1, 2,   W2, 0, 0, 3);
        add(0, 1, 0, 0,        1, 3,   W3, 0, 0, 4);
        add(0, 1, 0, 0,        0, 3,   W3, 1, 0, 4);
        add(1, 1, 0, 0,        0, 0,   0,  0, 0, 0);
        add(0, 0, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(0, 0, 0, 0,        1, 0,   W0, 0, 0, 1);
        add(1, 0, 0, 0,        0, 0,   0,  0, 0, 0);

        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            check("out_valid", i, {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            check("halted",    i, {31'b0, halted},    {31'b0, vecs[i].e_halted});
            check("fault",     i, {31'b0, fault},     {31'b0, vecs[i].e_fault});
            check("imem_pc",   i, imem_pc,            vecs[i].e_imem_pc);
            // Payload is only meaningful while valid, or right after reset clears it.
            if (vecs[i].e_valid || vecs[i].rst) begin
                check("out_pc",    i, out_pc,    vecs[i].e_pc);
                check("out_instr", i, out_instr, vecs[i].e_instr);
            end
        end

        // Bounded wait: halted must rise on the fifth edge after reset release.
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        while (!halted && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("halt_latency", 0, 32'(n), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
